// File: rtl/gt_align_pkg.sv
// Shared types and constants for the multi-lane 8b10b comma aligner.
//   lane_state_t      : per-lane alignment FSM states
//   COMMA_BYTE0_MASK  : rxctrl2 pattern for "comma in byte 0 only"
//   slip_modulus()    : number of distinct bitslip positions for a given
//                       RX data width (10 bits per 8b10b byte)
package gt_align_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SEARCH    = 3'd1,
        SLIP      = 3'd2,
        SLIP_WAIT = 3'd3,
        LOCKED    = 3'd4
    } lane_state_t;

    localparam int COMMA_BYTE0_MASK = 1;

    function automatic int slip_modulus(input int bytes);
        return 10 * bytes;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk  in  destination clock
//   rst  in  synchronous, active-high reset (clears the chain to 0)
//   d    in  asynchronous input level
//   q    out synchronised level, STAGES cycles of latency
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/comma_align_lane.sv
// One lane of the comma aligner: CDR-lock synchroniser, alignment FSM,
// timeout / comma / error / guard counters and the slip position counter.
// Ports:
//   rxusrclk2    in  RX user clock
//   rst          in  synchronous, active-high reset
//   rxcdrlock    in  asynchronous CDR lock for this lane
//   ctrl1/2/3    in  per-byte disparity error / comma / not-in-table
//   bitslip_rdy  in  slip path ready; qualifies commas
//   bitslip      out one-cycle slip request (high while in SLIP)
//   aligned      out lane is in LOCKED
//   align_fail   out one-cycle pulse when slip_cnt wraps to 0
//   slip_cnt     out current slip position, modulo 10*BYTES
//   state        out FSM state, for debug and checker binding
//
// bitslip_rdy is a level qualifier, not a handshake: a byte-0 comma seen
// while it is low is neither counted nor treated as an error.
module comma_align_lane import gt_align_pkg::*; #(
    parameter int BYTES            = 2,
    parameter int TIMEOUT_CYCLES   = 65535,
    parameter int LOCK_COMMAS      = 15,
    parameter int UNLOCK_ERRS      = 4,
    parameter int SLIP_WAIT_CYCLES = 32
) (
    input  logic              rxusrclk2,
    input  logic              rst,
    input  logic              rxcdrlock,
    input  logic [BYTES-1:0]  ctrl1,
    input  logic [BYTES-1:0]  ctrl2,
    input  logic [BYTES-1:0]  ctrl3,
    input  logic              bitslip_rdy,
    output logic              bitslip,
    output logic              aligned,
    output logic              align_fail,
    output logic [7:0]        slip_cnt,
    output lane_state_t       state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(LOCK_COMMAS + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);
    localparam int WW = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]    LOCK_TARGET  = CW'(LOCK_COMMAS);
    localparam logic [EW-1:0]    ERR_LIMIT    = EW'(UNLOCK_ERRS);
    localparam logic [WW-1:0]    WAIT_LAST    = WW'(SLIP_WAIT_CYCLES - 1);
    localparam logic [7:0]       SLIP_LAST    = 8'(slip_modulus(BYTES) - 1);
    localparam logic [BYTES-1:0] COMMA0       = BYTES'(COMMA_BYTE0_MASK);

    logic lock_s;
    logic is_comma0, misaligned, err, good;

    lane_state_t   state_n;
    logic [TW-1:0] timeout_cnt, timeout_n;
    logic [CW-1:0] comma_cnt, comma_n;
    logic [EW-1:0] err_cnt, err_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [7:0]    slip_n;
    logic          fail_n;

    bit_synchronizer #(.STAGES(2)) u_lock_sync (
        .clk (rxusrclk2),
        .rst (rst),
        .d   (rxcdrlock),
        .q   (lock_s)
    );

    // A comma in any byte other than byte 0 means the word boundary is off,
    // so it is folded into the error term; error wins over a coincident comma.
    assign is_comma0  = (ctrl2 == COMMA0);
    assign misaligned = (|ctrl2) && !is_comma0;
    assign err        = (|ctrl1) || (|ctrl3) || misaligned;
    assign good       = is_comma0 && bitslip_rdy && !err;

    always_comb begin
        state_n   = state;
        timeout_n = timeout_cnt;
        comma_n   = comma_cnt;
        err_n     = err_cnt;
        wait_n    = wait_cnt;
        slip_n    = slip_cnt;
        fail_n    = 1'b0;

        if (!lock_s) begin
            // Lock loss overrides everything; slip position is kept.
            state_n   = WAIT_LOCK;
            timeout_n = '0;
            comma_n   = '0;
            err_n     = '0;
            wait_n    = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state_n   = SEARCH;
                    timeout_n = '0;
                    comma_n   = '0;
                    err_n     = '0;
                end
                SEARCH: begin
                    if (err) begin
                        comma_n   = '0;
                        timeout_n = timeout_cnt + 1'b1;
                    end else if (good) begin
                        comma_n   = (comma_cnt < LOCK_TARGET) ? comma_cnt + 1'b1 : comma_cnt;
                        timeout_n = '0;
                    end else begin
                        timeout_n = timeout_cnt + 1'b1;
                    end

                    if (good && comma_n == LOCK_TARGET) begin
                        state_n   = LOCKED;
                        comma_n   = '0;
                        err_n     = '0;
                        timeout_n = '0;
                    end else if (!good && timeout_cnt == TIMEOUT_LAST) begin
                        // slip_cnt/align_fail update together with bitslip
                        state_n   = SLIP;
                        timeout_n = '0;
                        comma_n   = '0;
                        slip_n    = (slip_cnt == SLIP_LAST) ? 8'd0 : slip_cnt + 8'd1;
                        fail_n    = (slip_cnt == SLIP_LAST);
                    end
                end
                SLIP: begin
                    state_n = SLIP_WAIT;
                    wait_n  = '0;
                end
                SLIP_WAIT: begin
                    // Data is unstable right after a slip; ignore ctrl inputs.
                    if (wait_cnt == WAIT_LAST) begin
                        state_n   = SEARCH;
                        wait_n    = '0;
                        timeout_n = '0;
                        comma_n   = '0;
                        err_n     = '0;
                    end else begin
                        wait_n = wait_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (err) begin
                        err_n     = (err_cnt == ERR_LIMIT) ? err_cnt : err_cnt + 1'b1;
                        timeout_n = timeout_cnt + 1'b1;
                    end else if (good) begin
                        err_n     = '0;
                        timeout_n = '0;
                    end else begin
                        timeout_n = timeout_cnt + 1'b1;
                    end

                    if (err_n == ERR_LIMIT || (!good && timeout_cnt == TIMEOUT_LAST)) begin
                        state_n   = SEARCH;
                        timeout_n = '0;
                        comma_n   = '0;
                        err_n     = '0;
                    end
                end
                default: begin
                    state_n = WAIT_LOCK;
                end
            endcase
        end
    end

    always_ff @(posedge rxusrclk2) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            timeout_cnt <= '0;
            comma_cnt   <= '0;
            err_cnt     <= '0;
            wait_cnt    <= '0;
            slip_cnt    <= '0;
            bitslip     <= 1'b0;
            aligned     <= 1'b0;
            align_fail  <= 1'b0;
        end else begin
            state       <= state_n;
            timeout_cnt <= timeout_n;
            comma_cnt   <= comma_n;
            err_cnt     <= err_n;
            wait_cnt    <= wait_n;
            slip_cnt    <= slip_n;
            bitslip     <= (state_n == SLIP);
            aligned     <= (state_n == LOCKED);
            align_fail  <= fail_n;
        end
    end

endmodule

// File: rtl/gt_comma_aligner_mlane.sv
// Multi-lane comma alignment controller for GTH/GTY receivers running 8b10b
// with the transceiver's internal comma aligner disabled. Slices the lane-major
// RX PCS status buses, runs one comma_align_lane per lane and reduces the
// per-lane aligned flags.
// Ports:
//   rxusrclk2, rst                      clock, synchronous active-high reset
//   rxcdrlock[NUM_LANES]                per-lane async CDR lock
//   rxctrl1/2/3[NUM_LANES*BYTES]        per-byte status, lane-major
//   bitslip_rdy[NUM_LANES]              per-lane slip path ready
//   bitslip, aligned, align_fail        per-lane outputs
//   all_aligned                         registered AND of aligned
//   slip_cnt[NUM_LANES*8]               per-lane slip position
//   rxcommadeten..rx8b10ben             static transceiver configuration
//   lane_state[NUM_LANES]               per-lane FSM state (debug)
module gt_comma_aligner_mlane import gt_align_pkg::*; #(
    parameter int NUM_LANES        = 4,
    parameter int BYTES            = 2,
    parameter int TIMEOUT_CYCLES   = 65535,
    parameter int LOCK_COMMAS      = 15,
    parameter int UNLOCK_ERRS      = 4,
    parameter int SLIP_WAIT_CYCLES = 32
) (
    input  logic                        rxusrclk2,
    input  logic                        rst,
    input  logic [NUM_LANES-1:0]        rxcdrlock,
    input  logic [NUM_LANES*BYTES-1:0]  rxctrl1,
    input  logic [NUM_LANES*BYTES-1:0]  rxctrl2,
    input  logic [NUM_LANES*BYTES-1:0]  rxctrl3,
    input  logic [NUM_LANES-1:0]        bitslip_rdy,
    output logic [NUM_LANES-1:0]        bitslip,
    output logic [NUM_LANES-1:0]        aligned,
    output logic                        all_aligned,
    output logic [NUM_LANES*8-1:0]      slip_cnt,
    output logic [NUM_LANES-1:0]        align_fail,
    output logic                        rxcommadeten,
    output logic                        rxmcommaalignen,
    output logic                        rxpcommaalignen,
    output logic                        rx8b10ben,
    output lane_state_t [NUM_LANES-1:0] lane_state
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        comma_align_lane #(
            .BYTES            (BYTES),
            .TIMEOUT_CYCLES   (TIMEOUT_CYCLES),
            .LOCK_COMMAS      (LOCK_COMMAS),
            .UNLOCK_ERRS      (UNLOCK_ERRS),
            .SLIP_WAIT_CYCLES (SLIP_WAIT_CYCLES)
        ) u_lane (
            .rxusrclk2   (rxusrclk2),
            .rst         (rst),
            .rxcdrlock   (rxcdrlock[l]),
            .ctrl1       (rxctrl1[l*BYTES +: BYTES]),
            .ctrl2       (rxctrl2[l*BYTES +: BYTES]),
            .ctrl3       (rxctrl3[l*BYTES +: BYTES]),
            .bitslip_rdy (bitslip_rdy[l]),
            .bitslip     (bitslip[l]),
            .aligned     (aligned[l]),
            .align_fail  (align_fail[l]),
            .slip_cnt    (slip_cnt[l*8 +: 8]),
            .state       (lane_state[l])
        );
    end

    always_ff @(posedge rxusrclk2) begin
        if (rst) begin
            all_aligned <= 1'b0;
        end else begin
            all_aligned <= &aligned;
        end
    end

    // Comma detection stays on for rxctrl2; alignment is done here via bitslip.
    assign rxcommadeten    = 1'b1;
    assign rxmcommaalignen = 1'b0;
    assign rxpcommaalignen = 1'b0;
    assign rx8b10ben       = 1'b1;

endmodule
